// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexed Izhikevich scheduler: per-neuron state/config, req/ack engine sequencing, spike FIFO.
// Optional spike counter output is enabled by defining IZH_SCHED_SPIKE_COUNT_EN.
module izh_neuron_scheduler #(
  parameter int unsigned NUM_NEURONS = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned NW = $clog2(NUM_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          cfg_we,
  input  logic [NW-1:0] cfg_addr,
  input  logic [15:0]   cfg_data,
  output logic          dp_req,
  output logic [17:0]   dp_v,
  output logic [17:0]   dp_u,
  output logic [3:0]    dp_a,
  output logic [3:0]    dp_b,
  output logic [17:0]   dp_i,
  input  logic          dp_ack,
  input  logic [17:0]   dp_v_nxt,
  input  logic [17:0]   dp_u_nxt,
  input  logic          dp_spike,
  output logic          spk_valid,
  output logic [NW-1:0] spk_id,
  input  logic          spk_ready,
`ifdef IZH_SCHED_SPIKE_COUNT_EN
  output logic [NW:0]   spk_count,
`endif
  output logic          spk_ovf
);

  localparam int unsigned FW       = $clog2(FIFO_DEPTH);
  localparam int unsigned LAST     = NUM_NEURONS - 1;
  localparam logic [NW-1:0] LAST_IDX = LAST[NW-1:0];
  localparam logic [FW:0]   FULL_CNT = FIFO_DEPTH[FW:0];
  localparam logic [17:0]   V_RST    = 18'h3_4CCD;
  localparam logic [17:0]   U_RST    = 18'h3_CCCD;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_FIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [NW-1:0] r_idx;
  logic [17:0]   r_v [NUM_NEURONS];
  logic [17:0]   r_u [NUM_NEURONS];
  logic [3:0]    r_a [NUM_NEURONS];
  logic [3:0]    r_b [NUM_NEURONS];
  logic [7:0]    r_i [NUM_NEURONS];
  logic [17:0]   r_lat_v, r_lat_u;
  logic [3:0]    r_lat_a, r_lat_b;
  logic [7:0]    r_lat_i;
  logic [17:0]   r_res_v, r_res_u;
  logic          r_res_spk;
  logic [NW-1:0] r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_wr, r_rd;
  logic [FW:0]   r_cnt;
  logic          r_ovf;
  logic          w_capture, w_wb, w_last, w_full, w_push, w_push_ok, w_pop;
  logic [7:0]    w_i;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n)   r_state <= S_IDLE;
    else if (ena) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    dp_req      = 1'b0;
    w_capture   = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        busy        = 1'b1;
        dp_req      = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy   = 1'b1;
        dp_req = 1'b1;
        if (dp_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        busy        = 1'b1;
        w_wb        = 1'b1;
        w_state_nxt = w_last ? S_FIN : S_ISSUE;
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ISSUE shows the live entry; WAIT replays the copy latched at ISSUE so config writes cannot disturb it
  assign dp_v = (r_state == S_ISSUE) ? r_v[r_idx] : r_lat_v;
  assign dp_u = (r_state == S_ISSUE) ? r_u[r_idx] : r_lat_u;
  assign dp_a = (r_state == S_ISSUE) ? r_a[r_idx] : r_lat_a;
  assign dp_b = (r_state == S_ISSUE) ? r_b[r_idx] : r_lat_b;
  assign w_i  = (r_state == S_ISSUE) ? r_i[r_idx] : r_lat_i;
  assign dp_i = {w_i, 10'h0FF};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_lat_v   <= '0;
      r_lat_u   <= '0;
      r_lat_a   <= '0;
      r_lat_b   <= '0;
      r_lat_i   <= '0;
      r_res_v   <= '0;
      r_res_u   <= '0;
      r_res_spk <= 1'b0;
      for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
        r_v[k[NW-1:0]] <= V_RST;
        r_u[k[NW-1:0]] <= U_RST;
        r_a[k[NW-1:0]] <= '0;
        r_b[k[NW-1:0]] <= '0;
        r_i[k[NW-1:0]] <= '0;
      end
    end else begin
      if (cfg_we) begin
        r_a[cfg_addr] <= cfg_data[15:12];
        r_b[cfg_addr] <= cfg_data[11:8];
        r_i[cfg_addr] <= cfg_data[7:0];
      end
      if (ena) begin
        if (r_state == S_IDLE) r_idx <= '0;
        if (r_state == S_ISSUE) begin
          r_lat_v <= r_v[r_idx];
          r_lat_u <= r_u[r_idx];
          r_lat_a <= r_a[r_idx];
          r_lat_b <= r_b[r_idx];
          r_lat_i <= r_i[r_idx];
        end
        if (w_capture) begin
          r_res_v   <= dp_v_nxt;
          r_res_u   <= dp_u_nxt;
          r_res_spk <= dp_spike;
        end
        if (w_wb) begin
          r_v[r_idx] <= r_res_v;
          r_u[r_idx] <= r_res_u;
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign w_full    = (r_cnt == FULL_CNT);
  assign spk_valid = (r_cnt != '0);
  assign spk_id    = r_fifo[r_rd];
  assign spk_ovf   = r_ovf;
  assign w_push    = ena && w_wb && r_res_spk;
  assign w_pop     = ena && spk_valid && spk_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr] <= r_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef IZH_SCHED_SPIKE_COUNT_EN
  logic [NW:0] r_spk_run, r_spk_count;

  // Counts attempted pushes so dropped spikes are included
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_spk_run   <= '0;
      r_spk_count <= '0;
    end else if (ena) begin
      if (r_state == S_IDLE && start) r_spk_run <= '0;
      if (w_push)                     r_spk_run <= r_spk_run + 1'b1;
      if (r_state == S_FIN)           r_spk_count <= r_spk_run;
    end
  end

  assign spk_count = r_spk_count;
`endif

endmodule
